// File: rtl/cnn_axil_master.sv
// cnn_axil_master: single-outstanding host request/response -> AXI4-Lite initiator.
// Optional feature macro CNN_AXIL_POLL_EN: poll reads re-issue AR until (rdata & mask) != 0.
module cnn_axil_master #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int POLL_MAX = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_wr,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [DATA_W-1:0]   i_req_wdata,
    input  logic [DATA_W/8-1:0] i_req_wstrb,
    input  logic                i_req_poll,
    input  logic [DATA_W-1:0]   i_poll_mask,
    output logic                o_rsp_valid,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic [1:0]          o_rsp_resp,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_AW_W = 3'd1,
        S_WR_B    = 3'd2,
        S_RD_AR   = 3'd3,
        S_RD_R    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic                aw_hs_s, w_hs_s, aw_fin_s, w_fin_s;

`ifdef CNN_AXIL_POLL_EN
    localparam logic [8:0] POLL_MAX_W = 9'(POLL_MAX);
    logic                poll_q, poll_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [8:0]          beats_s;

    // R beats completed including the one currently handshaking
    assign beats_s = {1'b0, cnt_q} + 9'd1;
`else
    logic unused_poll_s;
    assign unused_poll_s = i_req_poll ^ (^i_poll_mask) ^ (POLL_MAX > 0);
`endif

    assign aw_hs_s  = awvalid_q & m_axi_awready;
    assign w_hs_s   = wvalid_q & m_axi_wready;
    assign aw_fin_s = aw_done_q | aw_hs_s;
    assign w_fin_s  = w_done_q | w_hs_s;

    // Next-state and output computation
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef CNN_AXIL_POLL_EN
        poll_d      = poll_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_req_valid && req_ready_q) begin
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    wstrb_d = i_req_wstrb;
`ifdef CNN_AXIL_POLL_EN
                    poll_d  = i_req_poll & ~i_req_wr;
                    mask_d  = i_poll_mask;
                    cnt_d   = 8'd0;
`endif
                    if (i_req_wr) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_AW_W;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RD_AR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_AW_W: begin
                // AW and W complete independently, in either order
                if (aw_hs_s) begin
                    awvalid_d = 1'b0;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (w_hs_s) begin
                    wvalid_d = 1'b0;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (aw_fin_s && w_fin_s) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = S_WR_B;
                end else begin
                    aw_done_d = aw_fin_s;
                    w_done_d  = w_fin_s;
                end
            end
            S_WR_B: begin
                if (m_axi_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi_bresp;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_WR_B;
                end
            end
            S_RD_AR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_R;
                end else begin
                    state_d = S_RD_AR;
                end
            end
            S_RD_R: begin
                if (m_axi_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
`ifdef CNN_AXIL_POLL_EN
                    if (poll_q && (m_axi_rresp == 2'b00) && ((m_axi_rdata & mask_q) == '0)) begin
                        if (beats_s >= POLL_MAX_W) begin
                            rsp_resp_d  = 2'b11;
                            rsp_valid_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            cnt_d     = cnt_q + 8'd1;
                            arvalid_d = 1'b1;
                            state_d   = S_RD_AR;
                        end
                    end else begin
                        rsp_valid_d = 1'b1;
                        state_d     = S_IDLE;
                    end
`else
                    rsp_valid_d = 1'b1;
                    state_d     = S_IDLE;
`endif
                end else begin
                    state_d = S_RD_R;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
`ifdef CNN_AXIL_POLL_EN
            poll_q      <= 1'b0;
            mask_q      <= '0;
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
`ifdef CNN_AXIL_POLL_EN
            poll_q      <= poll_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign o_req_ready   = req_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_resp    = rsp_resp_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule
